// File: rtl/snn_pkg.sv
// Shared types and defaults for the spiking-network vote classifier.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_ARGMAX = 2'd2,
        ST_DONE   = 2'd3
    } vote_state_t;

    localparam int DEFAULT_CNT_WIDTH = 8;

endpackage

// File: rtl/sat_vote_counter.sv
// Signed up/down vote counter for one output neuron; sticks at its signed limits.
module sat_vote_counter
    import snn_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        en,
    input  logic                        pos,
    input  logic                        neg,
    output logic signed [CNT_WIDTH-1:0] count
);

    localparam logic signed [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic signed [CNT_WIDTH-1:0] CNT_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
    localparam logic signed [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            // Opposing spikes in the same step cancel out.
            if (pos && !neg && count != CNT_MAX) begin
                count <= count + CNT_ONE;
            end else if (neg && !pos && count != CNT_MIN) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/spike_vote_classifier.sv
// Accumulates signed spike votes over a window of timesteps, then scans the
// per-class counters one per cycle to pick the winning class.
module spike_vote_classifier
    import snn_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int WINDOW      = 64,
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
    localparam int IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        step_valid,
    input  logic [NUM_CLASSES-1:0]      pos_spike,
    input  logic [NUM_CLASSES-1:0]      neg_spike,
    output logic                        busy,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [IDX_W-1:0]            class_idx,
    output logic signed [CNT_WIDTH-1:0] class_score,
    output vote_state_t                 state_dbg
);

    localparam int STEP_W = $clog2(WINDOW + 1);

    vote_state_t                 state;
    logic [STEP_W-1:0]           step_cnt;
    logic [IDX_W-1:0]            scan_idx;
    logic [IDX_W-1:0]            best_idx;
    logic signed [CNT_WIDTH-1:0] best_score;
    logic signed [CNT_WIDTH-1:0] counts [NUM_CLASSES];
    logic signed [CNT_WIDTH-1:0] cand_score;
    logic                        clear_cnt;
    logic                        step_en;
    logic                        last_step;
    logic                        last_scan;
    logic                        take;

    assign clear_cnt = (state == ST_IDLE) && start;
    assign step_en   = (state == ST_ACCUM) && step_valid;
    assign last_step = step_en && (step_cnt == STEP_W'(WINDOW - 1));
    assign last_scan = (scan_idx == IDX_W'(NUM_CLASSES - 1));
    assign state_dbg = state;

    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
        sat_vote_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear_cnt),
            .en    (step_en),
            .pos   (pos_spike[i]),
            .neg   (neg_spike[i]),
            .count (counts[i])
        );
    end

    // Index 0 seeds the running best; later classes need a strictly higher score.
    always_comb begin
        cand_score = counts[scan_idx];
        take       = (scan_idx == '0) || (cand_score > best_score);
    end

    // Result handshake: result_valid stays high with class_idx/class_score frozen
    // until a cycle with result_ready=1; that edge completes the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            step_cnt     <= '0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best_score   <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            class_idx    <= '0;
            class_score  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ACCUM;
                        step_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (step_valid) begin
                        step_cnt <= step_cnt + STEP_W'(1);
                        if (last_step) begin
                            state    <= ST_ARGMAX;
                            scan_idx <= '0;
                        end
                    end
                end
                ST_ARGMAX: begin
                    if (take) begin
                        best_idx   <= scan_idx;
                        best_score <= cand_score;
                    end
                    if (last_scan) begin
                        state        <= ST_DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        class_idx    <= take ? scan_idx : best_idx;
                        class_score  <= take ? cand_score : best_score;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state        <= ST_IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_vote_classifier.sv
// Bench for spike_vote_classifier: two instances (short window, long window)
// checked every cycle against a vote-tally model, plus literal expectations.
module tb_spike_vote_classifier;
    import snn_pkg::*;

    localparam int NC     = 10;
    localparam int CW     = 6;
    localparam int WIN_A  = 8;
    localparam int WIN_B  = 40;
    localparam int SAT_HI = 2 ** (CW - 1) - 1;
    localparam int SAT_LO = -(2 ** (CW - 1));

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                 start_v [2];
    logic                 step_valid;
    logic [NC-1:0]        pos_spike;
    logic [NC-1:0]        neg_spike;
    logic                 result_ready;
    logic                 busy_o  [2];
    logic                 rv_o    [2];
    logic [3:0]           idx_o   [2];
    logic signed [CW-1:0] score_o [2];
    vote_state_t          st_o    [2];

    int checks = 0;
    int errors = 0;

    spike_vote_classifier #(.NUM_CLASSES(NC), .WINDOW(WIN_A), .CNT_WIDTH(CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .step_valid(step_valid),
        .pos_spike(pos_spike), .neg_spike(neg_spike), .busy(busy_o[0]),
        .result_valid(rv_o[0]), .result_ready(result_ready), .class_idx(idx_o[0]),
        .class_score(score_o[0]), .state_dbg(st_o[0])
    );

    spike_vote_classifier #(.NUM_CLASSES(NC), .WINDOW(WIN_B), .CNT_WIDTH(CW)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .step_valid(step_valid),
        .pos_spike(pos_spike), .neg_spike(neg_spike), .busy(busy_o[1]),
        .result_valid(rv_o[1]), .result_ready(result_ready), .class_idx(idx_o[1]),
        .class_score(score_o[1]), .state_dbg(st_o[1])
    );

    function automatic int win_of(input int d);
        return (d == 0) ? WIN_A : WIN_B;
    endfunction

    function automatic int clamp_vote(input int v);
        if (v > SAT_HI) return SAT_HI;
        if (v < SAT_LO) return SAT_LO;
        return v;
    endfunction

    function automatic logic [NC-1:0] onehot(input int k);
        logic [NC-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 collecting votes, 2 scanning, 3 result offered
    int m_ph    [2];
    int m_votes [2][NC];
    int m_steps [2];
    int m_left  [2];
    int m_best  [2];
    int m_idx   [2];
    int m_score [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_ph[d] = 0; m_steps[d] = 0; m_left[d] = 0;
                m_best[d] = 0; m_idx[d] = 0; m_score[d] = 0;
                for (int i = 0; i < NC; i++) m_votes[d][i] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                case (m_ph[d])
                    0: if (start_v[d]) begin
                        m_ph[d]    = 1;
                        m_steps[d] = 0;
                        for (int i = 0; i < NC; i++) m_votes[d][i] = 0;
                    end
                    1: if (step_valid) begin
                        for (int i = 0; i < NC; i++)
                            m_votes[d][i] = clamp_vote(m_votes[d][i] + int'(pos_spike[i]) - int'(neg_spike[i]));
                        m_steps[d]++;
                        if (m_steps[d] == win_of(d)) begin
                            m_ph[d]   = 2;
                            m_left[d] = NC;
                            m_best[d] = 0;
                            for (int i = 1; i < NC; i++)
                                if (m_votes[d][i] > m_votes[d][m_best[d]]) m_best[d] = i;
                        end
                    end
                    2: begin
                        m_left[d]--;
                        if (m_left[d] == 0) begin
                            m_ph[d]    = 3;
                            m_idx[d]   = m_best[d];
                            m_score[d] = m_votes[d][m_best[d]];
                        end
                    end
                    3: if (result_ready) m_ph[d] = 0;
                    default: m_ph[d] = 0;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check("busy", d, int'(busy_o[d]), int'(m_ph[d] == 1 || m_ph[d] == 2));
            check("result_valid", d, int'(rv_o[d]), int'(m_ph[d] == 3));
            if (m_ph[d] != 2) begin
                check("class_idx", d, int'(idx_o[d]), m_idx[d]);
                check("class_score", d, int'(score_o[d]), m_score[d]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input int d);
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
    endtask

    task automatic do_step(input logic [NC-1:0] p, input logic [NC-1:0] n, input bit gap);
        if (gap) begin
            step_valid = 1'b0;
            pos_spike  = NC'($urandom);
            neg_spike  = NC'($urandom);
            @(posedge clk); #1;
        end
        step_valid = 1'b1;
        pos_spike  = p;
        neg_spike  = n;
        @(posedge clk); #1;
        step_valid = 1'b0;
        pos_spike  = NC'($urandom);
        neg_spike  = NC'($urandom);
    endtask

    // exp_idx < 0 leaves idx/score to the per-cycle compare.
    task automatic wait_result(input int d, input int exp_idx, input int exp_score,
                               input int hold, input bit poke);
        int n;
        n = 0;
        while (rv_o[d] !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", d, n, NC);
        if (exp_idx >= 0) begin
            check("lit_idx", d, int'(idx_o[d]), exp_idx);
            check("lit_score", d, int'(score_o[d]), exp_score);
        end
        for (int h = 0; h < hold; h++) begin
            start_v[d] = poke && (h == 1);
            @(posedge clk); #1;
            start_v[d] = 1'b0;
            check("hold_valid", d, int'(rv_o[d]), 1);
            if (exp_idx >= 0) begin
                check("hold_idx", d, int'(idx_o[d]), exp_idx);
                check("hold_score", d, int'(score_o[d]), exp_score);
            end
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("handshake", d, int'(rv_o[d]), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d;
        start_v[0]   = 1'b0;
        start_v[1]   = 1'b0;
        step_valid   = 1'b0;
        pos_spike    = '0;
        neg_spike    = '0;
        result_ready = 1'b0;
        rst_n        = 1'b1;
        #2 rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_busy", k, int'(busy_o[k]), 0);
            check("reset_valid", k, int'(rv_o[k]), 0);
            check("reset_idx", k, int'(idx_o[k]), 0);
            check("reset_score", k, int'(score_o[k]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single dominant class
        do_start(0);
        for (int s = 0; s < WIN_A; s++) do_step(onehot(3), '0, 1'b0);
        wait_result(0, 3, 8, 0, 1'b0);

        // tie between 2 and 7 goes to the lower index
        do_start(0);
        for (int s = 0; s < WIN_A; s++)
            do_step((s < 5 ? (onehot(2) | onehot(7)) : '0) | (s < 4 ? onehot(4) : '0), '0, 1'b0);
        wait_result(0, 2, 5, 0, 1'b0);

        // negative votes and cancelling spikes
        do_start(0);
        for (int s = 0; s < WIN_A; s++) do_step(onehot(5), onehot(0) | onehot(5), 1'b0);
        wait_result(0, 1, 0, 0, 1'b0);

        // gaps between steps, backpressure, start ignored while offering a result
        do_start(0);
        for (int s = 0; s < WIN_A; s++) do_step(onehot(6), '0, 1'b1);
        wait_result(0, 6, 8, 5, 1'b1);

        // reset in the middle of collecting votes
        do_start(0);
        for (int s = 0; s < 4; s++) do_step(onehot(4), '0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 0, int'(busy_o[0]), 0);
        check("abort_valid", 0, int'(rv_o[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            check("no_result_after_reset", 0, int'(rv_o[0]), 0);
        end
        do_start(0);
        for (int s = 0; s < WIN_A; s++) do_step(onehot(4), '0, 1'b0);
        wait_result(0, 4, 8, 0, 1'b0);

        // saturation on the long-window instance
        do_start(1);
        for (int s = 0; s < WIN_B; s++) do_step(onehot(9), '0, 1'b0);
        wait_result(1, 9, SAT_HI, 0, 1'b0);
        do_start(1);
        for (int s = 0; s < WIN_B; s++) do_step('0, '1, 1'b0);
        wait_result(1, 0, SAT_LO, 2, 1'b0);

        // randomized runs against the model
        for (int r = 0; r < 20; r++) begin
            d = (r % 5 == 4) ? 1 : 0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            do_start(d);
            for (int s = 0; s < win_of(d); s++)
                do_step(NC'($urandom) | (d == 1 ? onehot(r % NC) : '0),
                        NC'($urandom) & NC'($urandom), bit'($urandom_range(0, 1)));
            wait_result(d, -1, 0, $urandom_range(0, 3), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
